// File: rtl/shift_add_datapath_pkg.sv
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and constants for the shift-add multiplier family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_N = 4;

    typedef logic [1:0] mult_state_t;

    localparam mult_state_t c_ST_IDLE  = 2'd0;
    localparam mult_state_t c_ST_ARMED = 2'd1;
    localparam mult_state_t c_ST_RUN   = 2'd2;

    // Step counter has to reach N itself, hence N+1 distinct values.
    function automatic int step_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_datapath_if.sv
// ============================================================================
// Module   : shift_add_datapath_if
// Purpose  : Controller/datapath handshake bundle for the shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_add_datapath_if #(
    parameter int N = 4
) ();

    logic           start;
    logic           en;
    logic           flag;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] product;
    logic           done;
    logic           busy;
    logic           err;

    modport master (
        output start, en, flag, a, b,
        input  product, done, busy, err
    );

    modport slave (
        input  start, en, flag, a, b,
        output product, done, busy, err
    );

endinterface

`default_nettype wire

// File: rtl/shift_add_datapath_step.sv
// ============================================================================
// Module   : mult_step
// Purpose  : One combinational add/shift step of an unsigned shift-add multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step #(
    parameter int N = 4
) (
    input  wire logic [2*N-1:0] i_acc,
    input  wire logic [2*N-1:0] i_mcand,
    input  wire logic [N-1:0]   i_mplr,
    output logic      [2*N-1:0] o_acc,
    output logic      [2*N-1:0] o_mcand,
    output logic      [N-1:0]   o_mplr
);

    always_comb begin
        o_acc   = i_mplr[0] ? (i_acc + i_mcand) : i_acc;
        o_mcand = i_mcand << 1;
        o_mplr  = i_mplr >> 1;
    end

endmodule

`default_nettype wire

// File: rtl/shift_add_datapath.sv
// ============================================================================
// Module   : shift_add_datapath
// Purpose  : Shift-add multiplier responder: loads on start, steps on en,
//            publishes on en+flag and flags step-count protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  wire logic           clk,
    input  wire logic           rst,
    shift_add_datapath_if.slave bus
);

    localparam int              c_SW    = step_width(N);
    localparam logic [c_SW-1:0] c_STEPS = c_SW'(N);

    mult_state_t     r_state, w_state_nxt;
    logic [2*N-1:0]  r_mcand, w_mcand_nxt;
    logic [N-1:0]    r_mplr, w_mplr_nxt;
    logic [2*N-1:0]  r_acc, w_acc_nxt;
    logic [c_SW-1:0] r_step, w_step_nxt;
    logic [2*N-1:0]  r_product, w_product_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;

    logic [2*N-1:0]  w_step_acc;
    logic [2*N-1:0]  w_step_mcand;
    logic [N-1:0]    w_step_mplr;

    mult_step #(.N(N)) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mplr  (r_mplr),
        .o_acc   (w_step_acc),
        .o_mcand (w_step_mcand),
        .o_mplr  (w_step_mplr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_step    <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplr    <= w_mplr_nxt;
            r_acc     <= w_acc_nxt;
            r_step    <= w_step_nxt;
            r_product <= w_product_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplr_nxt    = r_mplr;
        w_acc_nxt     = r_acc;
        w_step_nxt    = r_step;
        w_product_nxt = r_product;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;

        // A new start discards whatever run is in flight, including a terminal cycle.
        if (bus.start) begin
            w_state_nxt = c_ST_ARMED;
            w_mcand_nxt = {{N{1'b0}}, bus.a};
            w_mplr_nxt  = bus.b;
            w_acc_nxt   = '0;
            w_step_nxt  = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_ST_ARMED, c_ST_RUN: begin
                    if (bus.en && bus.flag) begin
                        w_product_nxt = r_acc;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = c_ST_IDLE;
                        if (r_step != c_STEPS) begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (bus.en) begin
                        w_state_nxt = c_ST_RUN;
                        // Surplus steps freeze the datapath so the counter cannot wrap.
                        if (r_step == c_STEPS) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_acc_nxt   = w_step_acc;
                            w_mcand_nxt = w_step_mcand;
                            w_mplr_nxt  = w_step_mplr;
                            w_step_nxt  = r_step + 1'b1;
                        end
                    end else if (r_state == c_ST_RUN) begin
                        w_state_nxt = c_ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
                c_ST_IDLE: begin
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.product = r_product;
    assign bus.done    = r_done;
    assign bus.busy    = (r_state != c_ST_IDLE);
    assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_datapath.sv
// ============================================================================
// Module   : tb_shift_add_datapath
// Purpose  : Directed self-checking bench for shift_add_datapath (N=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_datapath;

    localparam int c_N = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    int   done_cnt;
    int   done_base;

    shift_add_datapath_if #(.N(c_N)) bus ();

    shift_add_datapath #(.N(c_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then land just after the capturing edge.
    task automatic cyc(input logic s, input logic e, input logic f,
                       input logic [c_N-1:0] aa, input logic [c_N-1:0] bb);
        bus.start = s;
        bus.en    = e;
        bus.flag  = f;
        bus.a     = aa;
        bus.b     = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic nominal(input logic [c_N-1:0] aa, input logic [c_N-1:0] bb);
        cyc(1'b1, 1'b0, 1'b0, aa, bb);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        bus.start = 1'b0; bus.en = 1'b0; bus.flag = 1'b0; bus.a = '0; bus.b = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_val("rst_product", 32'(bus.product), 32'd0);
        chk_val("rst_done",    32'(bus.done),    32'd0);
        chk_val("rst_busy",    32'(bus.busy),    32'd0);
        chk_val("rst_err",     32'(bus.err),     32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // 15 x 15
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 4'd15);
        chk_val("busy_after_start", 32'(bus.busy), 32'd1);
        chk_val("done_after_start", 32'(bus.done), 32'd0);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
        chk_val("p15x15",    32'(bus.product), 32'd225);
        chk_val("done15x15", 32'(bus.done),    32'd1);
        chk_val("err15x15",  32'(bus.err),     32'd0);
        chk_val("busy_fall", 32'(bus.busy),    32'd0);
        idle();
        chk_val("done_one_cycle", 32'(bus.done), 32'd0);

        // 0 x 9
        nominal(4'd0, 4'd9);
        chk_val("p0x9",    32'(bus.product), 32'd0);
        chk_val("done0x9", 32'(bus.done),    32'd1);
        chk_val("err0x9",  32'(bus.err),     32'd0);
        idle();

        // 13 x 11 with latency check: done must not appear before cycle N+2
        cyc(1'b1, 1'b0, 1'b0, 4'd13, 4'd11);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        chk_val("done_early", 32'(bus.done), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
        chk_val("p13x11",    32'(bus.product), 32'd143);
        chk_val("done13x11", 32'(bus.done),    32'd1);
        chk_val("err13x11",  32'(bus.err),     32'd0);
        idle();

        // en dropped after two steps
        done_base = done_cnt;
        cyc(1'b1, 1'b0, 1'b0, 4'd7, 4'd7);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        chk_val("drop_err",     32'(bus.err),     32'd1);
        chk_val("drop_busy",    32'(bus.busy),    32'd0);
        chk_val("drop_product", 32'(bus.product), 32'd143);
        chk_val("drop_no_done", 32'(done_cnt - done_base), 32'd0);

        // terminal after only three steps: 13 + 26 + 0 = 39
        cyc(1'b1, 1'b0, 1'b0, 4'd13, 4'd11);
        chk_val("start_clears_err", 32'(bus.err), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
        chk_val("short_done",    32'(bus.done),    32'd1);
        chk_val("short_err",     32'(bus.err),     32'd1);
        chk_val("short_product", 32'(bus.product), 32'd39);
        idle();

        // restart during step 2 of a 13x11 run
        done_base = done_cnt;
        cyc(1'b1, 1'b0, 1'b0, 4'd13, 4'd11);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 4'd5);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
        idle();
        chk_val("restart_product", 32'(bus.product), 32'd15);
        chk_val("restart_err",     32'(bus.err),     32'd0);
        chk_val("restart_dones",   32'(done_cnt - done_base), 32'd1);

        // start coinciding with a terminal cycle: start wins
        done_base = done_cnt;
        cyc(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
        chk_val("collide_product", 32'(bus.product), 32'd15);
        chk_val("collide_busy",    32'(bus.busy),    32'd1);
        for (int i = 0; i < c_N; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0);
        chk_val("collide_product2", 32'(bus.product), 32'd1);
        idle();
        chk_val("collide_dones", 32'(done_cnt - done_base), 32'd1);

        // surplus step sets err while running, then async reset mid-run
        cyc(1'b1, 1'b0, 1'b0, 4'd13, 4'd11);
        for (int i = 0; i < c_N + 1; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
        chk_val("surplus_err",  32'(bus.err),  32'd1);
        chk_val("surplus_busy", 32'(bus.busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk_val("arst_product", 32'(bus.product), 32'd0);
        chk_val("arst_busy",    32'(bus.busy),    32'd0);
        chk_val("arst_err",     32'(bus.err),     32'd0);
        bus.en = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        nominal(4'd13, 4'd11);
        chk_val("post_rst_product", 32'(bus.product), 32'd143);
        chk_val("post_rst_err",     32'(bus.err),     32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
